// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word collector.
// Optional even-parity support is selected by the SERIAL_WORD_PARITY_EN macro.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Even parity holds when the XOR over data bits and parity bit is zero.
  function automatic logic parity_ok(input logic data_xor, input logic par_bit);
    return ((data_xor ^ par_bit) == 1'b0);
  endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// LSB-first deserialising shift register with clear and a running XOR parity.
// The running parity exists only when SERIAL_WORD_PARITY_EN is defined.
module bit_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_parity
);

  logic [WIDTH-1:0] r_data;

  // Bits enter at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= {i_bit, r_data[WIDTH-1:1]};
    end else begin
      r_data <= r_data;
    end
  end

  assign o_data = r_data;

`ifdef SERIAL_WORD_PARITY_EN
  logic r_parity;

  // Running XOR of every data bit shifted in since the last clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (i_clr) begin
      r_parity <= 1'b0;
    end else if (i_shift) begin
      r_parity <= r_parity ^ i_bit;
    end else begin
      r_parity <= r_parity;
    end
  end

  assign o_parity = r_parity;
`else
  assign o_parity = 1'b0;
`endif

endmodule

// File: rtl/serial_word_collector.sv
// Collects framed LSB-first serial words from a qualified bit stream into a valid/ready output.
// Define SERIAL_WORD_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module serial_word_collector
  import serial_word_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_1,
  input  logic             bit_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_clr;
  logic             w_shift;
  logic             w_frame_ok;
  logic [WIDTH-1:0] w_sr_data;
  logic             w_sr_par;

  // Shift-register controls decoded from the current state and bit qualifier.
  always_comb begin
    w_clr   = 1'b0;
    w_shift = 1'b0;
    if (bit_vld) begin
      case (r_state)
        IDLE:    w_clr   = (in_1 == START_BIT);
        DATA:    w_shift = 1'b1;
        default: begin
          w_clr   = 1'b0;
          w_shift = 1'b0;
        end
      endcase
    end else begin
      w_clr   = 1'b0;
      w_shift = 1'b0;
    end
  end

  bit_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_bit   (in_1),
    .o_data  (w_sr_data),
    .o_parity(w_sr_par)
  );

`ifdef SERIAL_WORD_PARITY_EN
  logic r_par_bit;
  assign w_frame_ok = (in_1 == STOP_BIT) && parity_ok(w_sr_par, r_par_bit);
`else
  // Without parity the shift register reports a constant 0, so this reduces to the stop check.
  assign w_frame_ok = (in_1 == STOP_BIT) && parity_ok(w_sr_par, 1'b0);
`endif

  // Frame FSM plus output word register, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_WORD_PARITY_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (bit_vld) begin
        case (r_state)
          IDLE: begin
            if (in_1 == START_BIT) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
`ifdef SERIAL_WORD_PARITY_EN
              r_state <= PAR;
`else
              r_state <= STOP;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          PAR: begin
`ifdef SERIAL_WORD_PARITY_EN
            r_par_bit <= in_1;
            r_state   <= STOP;
`else
            r_state   <= IDLE;
`endif
          end
          STOP: begin
            r_state <= IDLE;
            if (w_frame_ok) begin
              // A held, unaccepted word wins; the new one is dropped and flagged.
              if (!r_valid || out_ready) begin
                r_data  <= w_sr_data;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector (WIDTH=8), table-driven plus corner sequences.
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_1;
  logic       bit_vld;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  serial_word_collector #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_1     (in_1),
    .bit_vld  (bit_vld),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_ovr;
    logic       exp_valid_after;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles (with junk on in_1) precede each qualified bit
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_vld = 1'b0;
      in_1    = ~b;
      step();
    end
    bit_vld = 1'b1;
    in_1    = b;
    step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
    send_bit(1'b1, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
`ifdef SERIAL_WORD_PARITY_EN
    send_bit(par, gap);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
    send_bit(stop, gap);
    bit_vld = 1'b0;
    in_1    = 1'b0;
  endtask

  task automatic idle();
    bit_vld = 1'b0;
    in_1    = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 3, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    in_1      = 1'b0;
    bit_vld   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    reset = 1'b0;
    idle();

    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop, vecs[v].gap);
      chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("v%0d_data", v),  32'(out_data),  32'(vecs[v].exp_data));
      chk($sformatf("v%0d_ferr", v),  32'(frame_err), 32'(vecs[v].exp_ferr));
      chk($sformatf("v%0d_ovr", v),   32'(overrun),   32'(vecs[v].exp_ovr));
      idle();
      chk($sformatf("v%0d_valid_after", v), 32'(out_valid), 32'(vecs[v].exp_valid_after));
      chk($sformatf("v%0d_ferr_after", v),  32'(frame_err), 32'd0);
    end

    // Overrun: second word dropped while the first is held
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 0);
    chk("ovr_first_valid", 32'(out_valid), 32'd1);
    chk("ovr_first_data",  32'(out_data),  32'h11);
    chk("ovr_first_flag",  32'(overrun),   32'd0);
    idle();
    send_frame(8'h22, 1'b0, 1'b0, 0);
    chk("ovr_pulse",      32'(overrun),   32'd1);
    chk("ovr_hold_data",  32'(out_data),  32'h11);
    chk("ovr_hold_valid", 32'(out_valid), 32'd1);
    chk("ovr_no_ferr",    32'(frame_err), 32'd0);
    idle();
    chk("ovr_pulse_end",  32'(overrun),   32'd0);
    chk("ovr_hold_data2", 32'(out_data),  32'h11);
    out_ready = 1'b1;
    idle();
    chk("ovr_consumed",   32'(out_valid), 32'd0);

    // Reset mid-frame with a held word
    out_ready = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 0);
    chk("mrst_pre_valid", 32'(out_valid), 32'd1);
    send_bit(1'b1, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    reset   = 1'b1;
    bit_vld = 1'b0;
    step();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data",  32'(out_data),  32'd0);
    chk("mrst_ferr",  32'(frame_err), 32'd0);
    chk("mrst_ovr",   32'(overrun),   32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    chk("mrst_new_valid", 32'(out_valid), 32'd1);
    chk("mrst_new_data",  32'(out_data),  32'h5A);
    chk("mrst_new_ferr",  32'(frame_err), 32'd0);
    idle();
    chk("mrst_consumed",  32'(out_valid), 32'd0);

`ifdef SERIAL_WORD_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0);
    chk("par_good_valid", 32'(out_valid), 32'd1);
    chk("par_good_data",  32'(out_data),  32'h07);
    chk("par_good_ferr",  32'(frame_err), 32'd0);
    idle();
    send_frame(8'h07, 1'b0, 1'b0, 0);
    chk("par_bad_ferr",  32'(frame_err), 32'd1);
    chk("par_bad_valid", 32'(out_valid), 32'd0);
    idle();
    chk("par_bad_ferr_end", 32'(frame_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
